turbosim_input_recorder: RTL

//  Synthesizable input-change recorder for the turbosim accelerator. Watches NUM_NETS encoded

---
 rtl/turbosim_input_recorder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/turbosim_input_recorder.sv
// Records input-net changes as 32-bit timestamped records and buffers them in a FIFO.
// On flush it drains the FIFO to turbosim, pulses go, then waits for the done handshake.
module turbosim_input_recorder #(
    parameter int unsigned NUM_NETS   = 16,
    parameter int unsigned BASE_INDEX = 0,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned TIME_STEP  = 20000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    capture_en,
    input  logic                    time_clr,
    input  logic [2*NUM_NETS-1:0]   in_val,
    input  logic                    flush,
    input  logic                    ds_full,
    output logic                    ds_wr,
    output logic [31:0]             ds_record,
    output logic                    ts_go,
    input  logic                    ts_done,
    output logic                    busy,
    output logic                    batch_done,
    output logic [ADDR_W:0]         fifo_count,
    output logic                    overflow,
    output logic [15:0]             drop_count,
    output logic [15:0]             coal_count
);
    localparam int unsigned IW = (NUM_NETS > 1) ? $clog2(NUM_NETS) : 1;
    localparam int unsigned CW = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_GO,
        S_WAIT_LOW,
        S_WAIT_HIGH
    } state_t;

    state_t                state_q, state_d;
    logic [2*NUM_NETS-1:0] snap_q;
    logic [NUM_NETS-1:0]   pend_q, pend_d;
    logic [NUM_NETS-1:0]   chg_c, coal_mask_c, push_bit_c;
    logic [1:0]            nval_q  [NUM_NETS];
    logic [15:0]           ntime_q [NUM_NETS];
    logic [15:0]           ts_q, ts_d;
    logic [31:0]           mem_q [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  push_req_c, push_ok_c, drop_c, pop_c;
    logic [IW-1:0]         push_idx_c;
    logic [31:0]           push_rec_c;
    logic [6:0]            coal_n_c;
    logic [16:0]           coal_sum_c;
    logic                  ds_wr_q, ts_go_q, ts_go_d, busy_q, batch_done_q, batch_done_d;
    logic                  overflow_q;
    logic [31:0]           ds_record_q;
    logic [15:0]           drop_q, coal_q;

    // Change detection, lowest-index-first scanner and coalesce accounting
    always_comb begin
        chg_c      = '0;
        push_req_c = 1'b0;
        push_idx_c = '0;
        coal_n_c   = '0;
        for (int i = 0; i < int'(NUM_NETS); i++) begin
            chg_c[i] = capture_en && (in_val[2*i +: 2] != snap_q[2*i +: 2]);
        end
        for (int i = int'(NUM_NETS) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                push_req_c = 1'b1;
                push_idx_c = IW'(i);
            end
        end
        push_bit_c  = NUM_NETS'(push_req_c) << push_idx_c;
        // A net being pushed this cycle and changing again starts a fresh record
        coal_mask_c = chg_c & pend_q & ~push_bit_c;
        for (int i = 0; i < int'(NUM_NETS); i++) begin
            coal_n_c = coal_n_c + 7'(coal_mask_c[i]);
        end
        pend_d = (pend_q & ~push_bit_c) | chg_c;
    end

    // FIFO control and timestamp
    always_comb begin
        push_rec_c = {nval_q[push_idx_c], 14'(BASE_INDEX) + 14'(push_idx_c), ntime_q[push_idx_c]};
        pop_c      = (state_q == S_DRAIN) && (count_q != '0) && !ds_full;
        push_ok_c  = push_req_c && ((count_q != CW'(DEPTH)) || pop_c);
        drop_c     = push_req_c && !push_ok_c;
        ts_d       = time_clr ? 16'd0 : (capture_en ? ts_q + 16'(TIME_STEP) : ts_q);
        coal_sum_c = {1'b0, coal_q} + 17'(coal_n_c);
    end

    // Flush sequencer next-state
    always_comb begin
        state_d      = state_q;
        ts_go_d      = 1'b0;
        batch_done_d = 1'b0;
        case (state_q)
            S_IDLE:      if (flush) state_d = S_DRAIN;
            S_DRAIN: begin
                if ((count_q == '0) && (pend_q == '0)) begin
                    state_d = S_GO;
                    ts_go_d = 1'b1;
                end
            end
            S_GO:        state_d = S_WAIT_LOW;
            S_WAIT_LOW:  if (!ts_done) state_d = S_WAIT_HIGH;
            S_WAIT_HIGH: begin
                if (ts_done) begin
                    state_d      = S_IDLE;
                    batch_done_d = 1'b1;
                end
            end
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            snap_q       <= '0;
            pend_q       <= '0;
            ts_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ds_wr_q      <= 1'b0;
            ds_record_q  <= '0;
            ts_go_q      <= 1'b0;
            busy_q       <= 1'b0;
            batch_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_q       <= '0;
            coal_q       <= '0;
            for (int i = 0; i < int'(NUM_NETS); i++) begin
                nval_q[i]  <= '0;
                ntime_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            snap_q       <= in_val;
            pend_q       <= pend_d;
            ts_q         <= ts_d;
            ts_go_q      <= ts_go_d;
            busy_q       <= (state_d != S_IDLE);
            batch_done_q <= batch_done_d;
            ds_wr_q      <= pop_c;
            for (int i = 0; i < int'(NUM_NETS); i++) begin
                if (chg_c[i]) begin
                    nval_q[i]  <= in_val[2*i +: 2];
                    ntime_q[i] <= ts_q;
                end
            end
            if (pop_c) begin
                ds_record_q <= mem_q[rd_ptr_q];
                rd_ptr_q    <= rd_ptr_q + 1'b1;
            end
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_ok_c) - CW'(pop_c);
            if (drop_c) begin
                overflow_q <= 1'b1;
                if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
            coal_q <= coal_sum_c[16] ? 16'hFFFF : coal_sum_c[15:0];
        end
    end

    // Record storage needs no reset: pointers guard every read
    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= push_rec_c;
    end

    assign ds_wr      = ds_wr_q;
    assign ds_record  = ds_record_q;
    assign ts_go      = ts_go_q;
    assign busy       = busy_q;
    assign batch_done = batch_done_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign coal_count = coal_q;

endmodule
